rom_fetch_sched: RTL and testbench

//  Schedules the single read port of the pixel ROM between display prefetch and one auxiliary requester.

---
 rtl/rom_fetch_sched.sv | 137 +++++++++++++
 tb/tb_rom_fetch_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_sched.sv
// rtl/rom_fetch_sched.sv - pixel ROM read-port scheduler: display prefetch vs one auxiliary requester
// Optional aux starvation guard enabled by defining ROM_SCHED_STARVE_GUARD_EN
`timescale 1ns/1ps
module rom_fetch_sched #(
    parameter int                ADDR_W       = 24,
    parameter int                DATA_W       = 24,
    parameter int                ROM_LAT      = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                FRAME_WORDS  = 307200,
    parameter int                AUX_MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              fifo_afull,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    localparam logic [1:0]        TAG_NONE  = 2'd0;
    localparam logic [1:0]        TAG_DISP  = 2'd1;
    localparam logic [1:0]        TAG_AUX   = 2'd2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(FRAME_WORDS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        tag_pipe [0:ROM_LAT];
    logic              disp_elig, disp_sel, aux_sel, kill, force_aux;

`ifdef ROM_SCHED_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(AUX_MAX_WAIT + 2);
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || !aux_req || aux_sel) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(AUX_MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_aux = aux_req && (wait_cnt == WAIT_W'(AUX_MAX_WAIT));
`else
    assign force_aux = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (frame_start) begin
                    state_nxt = S_FETCH;
                end else if (disp_sel && addr_cnt == LAST_ADDR) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  if (frame_start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A starved aux request pre-empts exactly one display slot.
    always_comb begin
        disp_elig  = (state == S_FETCH) && !fifo_afull && !frame_start;
        disp_sel   = disp_elig && !force_aux;
        aux_sel    = aux_req && !disp_sel;
        kill       = (state == S_FETCH) && frame_start;
        frame_done = (state == S_DONE);
    end

    // Killed display tags drop out as they advance; the word already at the
    // ROM output stage still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_en     <= 1'b0;
            rom_addr   <= '0;
            aux_gnt    <= 1'b0;
            addr_cnt   <= BASE_ADDR;
            fifo_wr_en <= 1'b0;
            fifo_wdata <= '0;
            aux_rvalid <= 1'b0;
            aux_rdata  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= TAG_NONE;
            end
        end else begin
            rom_en  <= disp_sel || aux_sel;
            aux_gnt <= aux_sel;
            if (disp_sel) begin
                rom_addr <= addr_cnt;
            end else if (aux_sel) begin
                rom_addr <= aux_addr;
            end

            if (frame_start) begin
                addr_cnt <= BASE_ADDR;
            end else if (disp_sel) begin
                addr_cnt <= addr_cnt + 1'b1;
            end

            tag_pipe[0] <= disp_sel ? TAG_DISP : (aux_sel ? TAG_AUX : TAG_NONE);
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= (kill && tag_pipe[k-1] == TAG_DISP) ? TAG_NONE : tag_pipe[k-1];
            end

            fifo_wr_en <= (tag_pipe[ROM_LAT] == TAG_DISP);
            if (tag_pipe[ROM_LAT] == TAG_DISP) begin
                fifo_wdata <= rom_rdata;
            end
            aux_rvalid <= (tag_pipe[ROM_LAT] == TAG_AUX);
            if (tag_pipe[ROM_LAT] == TAG_AUX) begin
                aux_rdata <= rom_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_sched.sv
// tb/tb_rom_fetch_sched.sv - self-checking bench for rom_fetch_sched at ROM_LAT 1 and 3
// Honours ROM_SCHED_STARVE_GUARD_EN to select the guard-off or guard-on aux scenario
`timescale 1ns/1ps
module tb_rom_fetch_sched;

    localparam int AW   = 24;
    localparam int DW   = 24;
    localparam int FW   = 8;
    localparam int MAXW = 4;
`ifdef ROM_SCHED_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          fifo_afull;
    logic          aux_req;
    logic [AW-1:0] aux_addr;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return (a * 24'd40503) ^ 24'hA5C31F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : 3;
        logic          fifo_wr_en, aux_gnt, aux_rvalid, rom_en, frame_done;
        logic [DW-1:0] fifo_wdata, aux_rdata, rom_rdata;
        logic [AW-1:0] rom_addr;
        logic [DW-1:0] rom_q [LAT];
        logic [DW-1:0] fq_data[$], aq_data[$];
        int            fq_cyc[$], aq_cyc[$];
        int            nwr, naux, m_state, m_wait, c;
        logic [AW-1:0] m_cnt, exp_addr;
        logic          exp_en, exp_gnt, elig, frc, d_disp, d_aux;
        string         pfx;

        rom_fetch_sched #(
            .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .BASE_ADDR(24'd0),
            .FRAME_WORDS(FW), .AUX_MAX_WAIT(MAXW)
        ) u_dut (
            .clk(clk), .rst(rst), .frame_start(frame_start), .fifo_afull(fifo_afull),
            .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
            .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
            .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
            .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
            .frame_done(frame_done)
        );

        // ROM model: data for the address seen in cycle t is valid in cycle t+LAT
        always @(posedge clk) begin
            rom_q[0] <= rom_word(rom_addr);
            for (int k = 1; k < LAT; k++) rom_q[k] <= rom_q[k-1];
        end
        assign rom_rdata = rom_q[LAT-1];

        initial begin
            pfx = (g == 0) ? "lat1_" : "lat3_";
            m_state = 0; m_cnt = '0; m_wait = 0; nwr = 0; naux = 0;
            exp_en = 1'b0; exp_gnt = 1'b0; exp_addr = '0;
            forever begin
                @(negedge clk);
                c = cyc;
                if (rst) begin
                    fq_data.delete(); fq_cyc.delete(); aq_data.delete(); aq_cyc.delete();
                    m_state = 0; m_cnt = '0; m_wait = 0; exp_en = 1'b0; exp_gnt = 1'b0;
                end else begin
                    chk({pfx, "rom_en"}, 32'(rom_en), 32'(exp_en));
                    chk({pfx, "aux_gnt"}, 32'(aux_gnt), 32'(exp_gnt));
                    if (exp_en) chk({pfx, "rom_addr"}, 32'(rom_addr), 32'(exp_addr));
                    chk({pfx, "frame_done"}, 32'(frame_done), 32'(m_state == 2));
                    if (fifo_wr_en) begin
                        nwr++;
                        chk({pfx, "fifo_expected"}, 32'(fq_cyc.size() > 0), 32'd1);
                        if (fq_cyc.size() > 0) begin
                            chk({pfx, "fifo_wdata"}, 32'(fifo_wdata), 32'(fq_data[0]));
                            chk({pfx, "fifo_cycle"}, 32'(c), 32'(fq_cyc[0]));
                            void'(fq_cyc.pop_front()); void'(fq_data.pop_front());
                        end
                    end else if (fq_cyc.size() > 0 && fq_cyc[0] <= c) begin
                        chk({pfx, "fifo_wr_en_due"}, 32'(fifo_wr_en), 32'd1);
                        void'(fq_cyc.pop_front()); void'(fq_data.pop_front());
                    end
                    if (aux_rvalid) begin
                        naux++;
                        chk({pfx, "aux_expected"}, 32'(aq_cyc.size() > 0), 32'd1);
                        if (aq_cyc.size() > 0) begin
                            chk({pfx, "aux_rdata"}, 32'(aux_rdata), 32'(aq_data[0]));
                            chk({pfx, "aux_cycle"}, 32'(c), 32'(aq_cyc[0]));
                            void'(aq_cyc.pop_front()); void'(aq_data.pop_front());
                        end
                    end else if (aq_cyc.size() > 0 && aq_cyc[0] <= c) begin
                        chk({pfx, "aux_rvalid_due"}, 32'(aux_rvalid), 32'd1);
                        void'(aq_cyc.pop_front()); void'(aq_data.pop_front());
                    end

                    elig   = (m_state == 1) && !fifo_afull && !frame_start;
                    frc    = GUARD && aux_req && (m_wait == MAXW);
                    d_disp = elig && !frc;
                    d_aux  = aux_req && !d_disp;
                    exp_en = d_disp || d_aux;
                    exp_gnt = d_aux;
                    exp_addr = d_disp ? m_cnt : aux_addr;
                    if (d_disp) begin
                        fq_data.push_back(rom_word(m_cnt));
                        fq_cyc.push_back(c + LAT + 2);
                    end
                    if (d_aux) begin
                        aq_data.push_back(rom_word(aux_addr));
                        aq_cyc.push_back(c + LAT + 2);
                    end
                    if (!aux_req || d_aux) m_wait = 0;
                    else if (m_wait < MAXW) m_wait++;
                    // restart kills display words still inside the ROM
                    if (m_state == 1 && frame_start) begin
                        for (int i = fq_cyc.size() - 1; i >= 0; i--) begin
                            if (fq_cyc[i] >= c + 2) begin
                                fq_cyc.delete(i); fq_data.delete(i);
                            end
                        end
                    end
                    if (frame_start) begin
                        m_state = 1; m_cnt = '0;
                    end else if (d_disp) begin
                        if (m_cnt == AW'(FW - 1)) m_state = 2;
                        m_cnt = m_cnt + 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string p, input logic en, gnt, wr, rv, fd,
                            input logic [AW-1:0] ad, input logic [DW-1:0] wd, rd);
        chk({p, "rst_rom_en"}, 32'(en), 32'd0);
        chk({p, "rst_aux_gnt"}, 32'(gnt), 32'd0);
        chk({p, "rst_fifo_wr_en"}, 32'(wr), 32'd0);
        chk({p, "rst_aux_rvalid"}, 32'(rv), 32'd0);
        chk({p, "rst_frame_done"}, 32'(fd), 32'd0);
        chk({p, "rst_rom_addr"}, 32'(ad), 32'd0);
        chk({p, "rst_fifo_wdata"}, 32'(wd), 32'd0);
        chk({p, "rst_aux_rdata"}, 32'(rd), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk_zero("lat1_", gi[0].rom_en, gi[0].aux_gnt, gi[0].fifo_wr_en, gi[0].aux_rvalid,
                 gi[0].frame_done, gi[0].rom_addr, gi[0].fifo_wdata, gi[0].aux_rdata);
        chk_zero("lat3_", gi[1].rom_en, gi[1].aux_gnt, gi[1].fifo_wr_en, gi[1].aux_rvalid,
                 gi[1].frame_done, gi[1].rom_addr, gi[1].fifo_wdata, gi[1].aux_rdata);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!gi[0].frame_done && n < 40) begin
            tick(1);
            n++;
        end
        chk("frame_done_reached", 32'(gi[0].frame_done), 32'd1);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, w1, cnt;
        rst = 1'b1; frame_start = 1'b0; fifo_afull = 1'b0; aux_req = 1'b0; aux_addr = '0;
        tick(3);
        check_reset_outputs();
        rst = 1'b0;
        tick(3);
        chk("idle_no_issue", 32'(gi[0].rom_en), 32'd0);
        chk("idle_not_done", 32'(gi[0].frame_done), 32'd0);

        // whole frame, no back-pressure
        w0 = gi[0].nwr; w1 = gi[1].nwr;
        pulse_start();
        wait_done(n);
        chk("t1_cycles_to_done", 32'(n), 32'd8);
        tick(6);
        chk("t1_lat1_writes", 32'(gi[0].nwr - w0), 32'd8);
        chk("t1_lat3_writes", 32'(gi[1].nwr - w1), 32'd8);

        // almost-full for 5 cycles mid-fetch
        w0 = gi[0].nwr; w1 = gi[1].nwr;
        pulse_start();
        tick(3);
        fifo_afull = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (gi[0].rom_en) cnt++;
        end
        fifo_afull = 1'b0;
        chk("t2_no_issue_afull", 32'(cnt), 32'd0);
        tick(1);
        chk("t2_resume_en", 32'(gi[0].rom_en), 32'd1);
        chk("t2_resume_addr", 32'(gi[0].rom_addr), 32'd3);
        wait_done(n);
        tick(6);
        chk("t2_lat1_writes", 32'(gi[0].nwr - w0), 32'd8);
        chk("t2_lat3_writes", 32'(gi[1].nwr - w1), 32'd8);

`ifdef ROM_SCHED_STARVE_GUARD_EN
        // starvation guard forces one aux slot
        pulse_start();
        aux_addr = 24'h200; aux_req = 1'b1;
        n = 0;
        while (!gi[0].aux_gnt && n < 20) begin
            tick(1);
            if (!gi[0].aux_gnt) n++;
        end
        aux_req = 1'b0;
        chk("t4_wait_cycles", 32'(n), 32'(MAXW));
        chk("t4_aux_addr", 32'(gi[0].rom_addr), 32'h200);
        tick(1);
        chk("t4_display_resumes", 32'(gi[0].rom_addr), 32'd4);
        wait_done(n);
        tick(6);
`else
        // strict display priority: aux waits for back-pressure
        pulse_start();
        aux_addr = 24'h100; aux_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t3_no_gnt_while_display", 32'(gi[0].aux_gnt), 32'd0);
        end
        fifo_afull = 1'b1;
        tick(1);
        chk("t3_gnt_on_afull", 32'(gi[0].aux_gnt), 32'd1);
        aux_req = 1'b0;
        chk("t3_aux_addr", 32'(gi[0].rom_addr), 32'h100);
        tick(2);
        chk("t3_aux_rvalid", 32'(gi[0].aux_rvalid), 32'd1);
        chk("t3_aux_rdata", 32'(gi[0].aux_rdata), 32'(rom_word(24'h100)));
        fifo_afull = 1'b0;
        wait_done(n);
        tick(6);
`endif

        // restart at word 5: words still inside the ROM are dropped
        pulse_start();
        tick(4);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        w1 = gi[1].nwr;
        chk("t5_no_issue_on_restart", 32'(gi[1].rom_en), 32'd0);
        tick(1);
        chk("t5_restart_en", 32'(gi[1].rom_en), 32'd1);
        chk("t5_restart_addr", 32'(gi[1].rom_addr), 32'd0);
        tick(4);
        chk("t5_lat3_old_writes", 32'(gi[1].nwr - w1), 32'd1);
        wait_done(n);
        tick(6);

        // reset with reads in flight
        pulse_start();
        tick(1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("t6_lat1_no_strobe", 32'(gi[0].fifo_wr_en | gi[0].aux_rvalid | gi[0].rom_en), 32'd0);
            chk("t6_lat3_no_strobe", 32'(gi[1].fifo_wr_en | gi[1].aux_rvalid | gi[1].rom_en), 32'd0);
        end
        chk("t6_idle_not_done", 32'(gi[0].frame_done), 32'd0);
        w0 = gi[0].nwr;
        pulse_start();
        wait_done(n);
        tick(8);
        chk("t6_frame_after_reset", 32'(gi[0].nwr - w0), 32'd8);

        chk("lat1_fifo_drained", 32'(gi[0].fq_cyc.size()), 32'd0);
        chk("lat3_fifo_drained", 32'(gi[1].fq_cyc.size()), 32'd0);
        chk("lat1_aux_drained", 32'(gi[0].aq_cyc.size()), 32'd0);
        chk("lat3_aux_drained", 32'(gi[1].aq_cyc.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
